// File: rtl/ipv4_hdr_gen.sv
// ipv4_hdr_gen
//   IPv4 header generator for the Ethernet TX path, with an optional UDP header.
//   A rising edge on i_trig makes the block write a complete header into the TX
//   header buffer, one byte per cycle. The header checksum is built up while the
//   bytes go out, and the two checksum bytes are patched in after the sweep. Every
//   packet takes the current identification counter, which then increments.
//   Source and destination IPs can be changed at run time. A set request that
//   arrives during a build is held and applied once the block is idle again.
//
// Optional feature macro: UDP_HDR_EN
//   When defined, an 8-byte UDP header (ports, length, zero checksum) follows
//   the IP header, and the IP total length includes it.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_trig              rising edge starts a header build
//   i_data_length       payload length, sampled on the trigger-edge cycle
//   i_ip                value loaded by i_set_local / i_set_dest
//   i_set_local         rising edge loads i_ip into the source IP
//   i_set_dest          rising edge loads i_ip into the destination IP
//   i_src_port          UDP source port (used only with UDP_HDR_EN)
//   i_dst_port          UDP destination port (used only with UDP_HDR_EN)
//   o_hdr_idx           header buffer write address (HDR_BASE + offset)
//   o_hdr_byte          header buffer write data
//   o_wr_en             header buffer write strobe
//   o_local_ip          current source IP
//   o_ident             identification value for the next packet
//   o_busy              build in progress
//   o_ready             header complete; held until the next accepted trigger
module ipv4_hdr_gen #(
  parameter int          ADDR_W     = 6,
  parameter int          HDR_BASE   = 0,
  parameter logic [7:0]  TTL        = 8'h80,
  parameter logic [7:0]  PROTO      = 8'h11,
  parameter logic [31:0] INIT_SRCIP = 32'hC0A80104,
  parameter logic [31:0] INIT_DSTIP = 32'hC0A80105
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_trig,
  input  logic [15:0]       i_data_length,
  input  logic [31:0]       i_ip,
  input  logic              i_set_local,
  input  logic              i_set_dest,
  input  logic [15:0]       i_src_port,
  input  logic [15:0]       i_dst_port,
  output logic [ADDR_W-1:0] o_hdr_idx,
  output logic [7:0]        o_hdr_byte,
  output logic              o_wr_en,
  output logic [31:0]       o_local_ip,
  output logic [15:0]       o_ident,
  output logic              o_busy,
  output logic              o_ready
);

`ifdef UDP_HDR_EN
  localparam logic [4:0]  LAST_OFS = 5'd27;
  localparam logic [15:0] LEN_ADD  = 16'd28;
`else
  localparam logic [4:0]  LAST_OFS = 5'd19;
  localparam logic [15:0] LEN_ADD  = 16'd20;
`endif
  // The IP header has 10 16-bit words. Only these words go into the checksum.
  localparam logic [3:0] CSUM_WORDS = 4'd10;

  // Ones-complement add. The carry out of bit 15 is folded back in straight away.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_SWEEP, S_PATCH_HI, S_PATCH_LO, S_DONE, S_SET
  } state_t;

  state_t      state, state_nxt;
  logic        trig_q, set_local_q, set_dest_q;
  logic        trig_edge, local_edge, dest_edge;
  logic        pend_local, pend_dest;
  logic        start;
  logic        busy, ready;
  logic [4:0]  ofs;
  logic [15:0] tot_len, csum, ident, hdr_word;
  logic [31:0] src_ip, dst_ip;
  logic [7:0]  sweep_byte;
`ifdef UDP_HDR_EN
  logic [15:0] udp_len;
`else
  logic        unused_ports;
  assign unused_ports = ^{i_src_port, i_dst_port};
`endif

  assign trig_edge  = i_trig & ~trig_q;
  assign local_edge = i_set_local & ~set_local_q;
  assign dest_edge  = i_set_dest & ~set_dest_q;

  // A set request that is already pending is applied before a new trigger is
  // accepted. A fresh trigger beats a fresh set edge that arrives in the same
  // cycle; that set edge becomes pending.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pend_local || pend_dest)      state_nxt = S_SET;
        else if (trig_edge)               state_nxt = S_SWEEP;
        else if (local_edge || dest_edge) state_nxt = S_SET;
      end
      S_SWEEP:    if (ofs == LAST_OFS) state_nxt = S_PATCH_HI;
      S_PATCH_HI: state_nxt = S_PATCH_LO;
      S_PATCH_LO: state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      S_SET:      state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  assign start = (state == S_IDLE) && (state_nxt == S_SWEEP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trig_q      <= 1'b0;
      set_local_q <= 1'b0;
      set_dest_q  <= 1'b0;
      pend_local  <= 1'b0;
      pend_dest   <= 1'b0;
      ofs         <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      ident       <= '0;
      src_ip      <= INIT_SRCIP;
      dst_ip      <= INIT_DSTIP;
    end else begin
      trig_q      <= i_trig;
      set_local_q <= i_set_local;
      set_dest_q  <= i_set_dest;

      if (start)                 ofs <= '0;
      else if (state == S_SWEEP) ofs <= ofs + 5'd1;

      if (start) begin
        busy  <= 1'b1;
        ready <= 1'b0;
      end else if (state == S_PATCH_LO) begin
        busy  <= 1'b0;
        ready <= 1'b1;
        ident <= ident + 16'd1;
      end

      // Both registers load the same i_ip when local and dest are requested together.
      if (state == S_SET) begin
        if (pend_local || local_edge) src_ip <= i_ip;
        if (pend_dest || dest_edge)   dst_ip <= i_ip;
        pend_local <= 1'b0;
        pend_dest  <= 1'b0;
      end else begin
        pend_local <= pend_local | local_edge;
        pend_dest  <= pend_dest | dest_edge;
      end
    end
  end

  // Lengths are latched on the trigger. The checksum takes each IP word in the
  // cycle that writes the word's low byte.
  always_ff @(posedge i_clk) begin
    if (start) begin
      tot_len <= i_data_length + LEN_ADD;
      csum    <= '0;
`ifdef UDP_HDR_EN
      udp_len <= i_data_length + 16'd8;
`endif
    end else if (state == S_SWEEP && ofs[0] && ofs[4:1] < CSUM_WORDS) begin
      csum <= ones_add(csum, hdr_word);
    end
  end

  // Select the header word for the current offset. Word 5 is the checksum field.
  // It goes out as zero during the sweep and is patched afterwards.
  always_comb begin
    hdr_word = '0;
    case (ofs[4:1])
      4'd0:  hdr_word = 16'h4500;
      4'd1:  hdr_word = tot_len;
      4'd2:  hdr_word = ident;
      4'd3:  hdr_word = 16'h4000;
      4'd4:  hdr_word = {TTL, PROTO};
      4'd5:  hdr_word = 16'h0000;
      4'd6:  hdr_word = src_ip[31:16];
      4'd7:  hdr_word = src_ip[15:0];
      4'd8:  hdr_word = dst_ip[31:16];
      4'd9:  hdr_word = dst_ip[15:0];
`ifdef UDP_HDR_EN
      4'd10: hdr_word = i_src_port;
      4'd11: hdr_word = i_dst_port;
      4'd12: hdr_word = udp_len;
`endif
      default: hdr_word = '0;
    endcase
    sweep_byte = ofs[0] ? hdr_word[7:0] : hdr_word[15:8];
  end

  always_comb begin
    o_wr_en    = 1'b0;
    o_hdr_idx  = '0;
    o_hdr_byte = '0;
    case (state)
      S_SWEEP: begin
        o_wr_en    = 1'b1;
        o_hdr_idx  = ADDR_W'(HDR_BASE) + ADDR_W'(ofs);
        o_hdr_byte = sweep_byte;
      end
      S_PATCH_HI: begin
        o_wr_en    = 1'b1;
        o_hdr_idx  = ADDR_W'(HDR_BASE) + ADDR_W'(10);
        o_hdr_byte = ~csum[15:8];
      end
      S_PATCH_LO: begin
        o_wr_en    = 1'b1;
        o_hdr_idx  = ADDR_W'(HDR_BASE) + ADDR_W'(11);
        o_hdr_byte = ~csum[7:0];
      end
      default: ;
    endcase
  end

  assign o_local_ip = src_ip;
  assign o_ident    = ident;
  assign o_busy     = busy;
  assign o_ready    = ready;

endmodule

// File: tb/tb_ipv4_hdr_gen.sv
// Directed bench for ipv4_hdr_gen. Expected header bytes and checksums are
// hand-computed constants. Some later checksums come from a small
// ones-complement model.
module tb_ipv4_hdr_gen;

`ifdef UDP_HDR_EN
  localparam int          HL  = 28;
  localparam logic [15:0] TOT = 16'h0024;
  localparam logic [15:0] CK1 = 16'h776F;
  localparam logic [15:0] CK2 = 16'h776E;
`else
  localparam int          HL  = 20;
  localparam logic [15:0] TOT = 16'h001C;
  localparam logic [15:0] CK1 = 16'h7777;
  localparam logic [15:0] CK2 = 16'h7776;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_trig = 1'b0;
  logic [15:0] i_data_length = '0;
  logic [31:0] i_ip = '0;
  logic        i_set_local = 1'b0;
  logic        i_set_dest = 1'b0;
  logic [15:0] i_src_port = 16'h1234;
  logic [15:0] i_dst_port = 16'h5678;
  logic [5:0]  o_hdr_idx;
  logic [7:0]  o_hdr_byte;
  logic        o_wr_en;
  logic [31:0] o_local_ip;
  logic [15:0] o_ident;
  logic        o_busy;
  logic        o_ready;

  always #5 i_clk = ~i_clk;

  ipv4_hdr_gen dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_trig(i_trig), .i_data_length(i_data_length),
    .i_ip(i_ip), .i_set_local(i_set_local), .i_set_dest(i_set_dest),
    .i_src_port(i_src_port), .i_dst_port(i_dst_port),
    .o_hdr_idx(o_hdr_idx), .o_hdr_byte(o_hdr_byte), .o_wr_en(o_wr_en),
    .o_local_ip(o_local_ip), .o_ident(o_ident), .o_busy(o_busy), .o_ready(o_ready)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         nwr, lat;
  logic [7:0] mem     [0:63];
  logic [5:0] wr_idx  [0:63];
  logic [7:0] wr_byte [0:63];
  logic [7:0] exp1    [0:27];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [15:0] csum_model(input logic [15:0] tot, input logic [15:0] id,
                                             input logic [31:0] src, input logic [31:0] dst);
    logic [31:0] s;
    s = 32'h4500 + 32'(tot) + 32'(id) + 32'h4000 + 32'h8011
      + 32'(src[31:16]) + 32'(src[15:0]) + 32'(dst[31:16]) + 32'(dst[15:0]);
    while (s[31:16] != 16'd0) s = 32'(s[15:0]) + 32'(s[31:16]);
    return ~s[15:0];
  endfunction

  // Starts a build and logs every write until o_ready rises or 60 cycles pass.
  // It can re-pulse the trigger, or pulse set_local, at a chosen cycle.
  task automatic build(input logic [15:0] len, input int repulse_at,
                       input int set_at, input logic [31:0] set_val);
    for (int k = 0; k < 64; k++) mem[k] = 8'h00;
    nwr = 0;
    i_data_length = len;
    i_trig = 1'b1;
    tick();
    i_trig = 1'b0;
    lat = 1;
    while (!o_ready && lat < 60) begin
      if (o_wr_en) begin
        if (nwr < 64) begin
          wr_idx[nwr]  = o_hdr_idx;
          wr_byte[nwr] = o_hdr_byte;
        end
        mem[o_hdr_idx] = o_hdr_byte;
        nwr++;
      end
      i_trig = (lat == repulse_at);
      if (lat == set_at) begin
        i_ip = set_val;
        i_set_local = 1'b1;
      end else begin
        i_set_local = 1'b0;
      end
      tick();
      lat++;
    end
    i_trig = 1'b0;
    i_set_local = 1'b0;
    chk("build_ready_timeout", 32'(o_ready), 32'd1);
  endtask

  initial begin
`ifdef UDP_HDR_EN
    exp1 = '{8'h45, 8'h00, 8'h00, 8'h24, 8'h00, 8'h00, 8'h40, 8'h00, 8'h80, 8'h11,
             8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h04, 8'hC0, 8'hA8, 8'h01, 8'h05,
             8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h10, 8'h00, 8'h00};
`else
    exp1 = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h40, 8'h00, 8'h80, 8'h11,
             8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h04, 8'hC0, 8'hA8, 8'h01, 8'h05,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    // Reset state
    tick(); tick();
    chk("rst_wr_en", 32'(o_wr_en), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    i_rst_n = 1'b1;
    tick(); tick();
    chk("idle_wr_en", 32'(o_wr_en), 32'd0);
    chk("idle_idx", 32'(o_hdr_idx), 32'd0);
    chk("idle_byte", 32'(o_hdr_byte), 32'd0);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_ready", 32'(o_ready), 32'd0);
    chk("idle_ident", 32'(o_ident), 32'd0);
    chk("idle_local_ip", o_local_ip, 32'hC0A80104);

    // Build 1: the full byte stream, the patches and the latency
    build(16'h0008, 0, 0, 32'h0);
    chk("b1_latency", 32'(lat), 32'(HL + 3));
    chk("b1_nwrites", 32'(nwr), 32'(HL + 2));
    for (int i = 0; i < HL; i++) begin
      chk("b1_sweep_idx", 32'(wr_idx[i]), 32'(i));
      chk("b1_sweep_byte", 32'(wr_byte[i]), 32'(exp1[i]));
    end
    chk("b1_patch_hi_idx", 32'(wr_idx[HL]), 32'd10);
    chk("b1_patch_hi", 32'(wr_byte[HL]), 32'(CK1[15:8]));
    chk("b1_patch_lo_idx", 32'(wr_idx[HL+1]), 32'd11);
    chk("b1_patch_lo", 32'(wr_byte[HL+1]), 32'(CK1[7:0]));
    chk("b1_ident", 32'(o_ident), 32'h0001);
    chk("b1_busy", 32'(o_busy), 32'd0);

    // Build 2: the ID increments
    tick();
    build(16'h0008, 0, 0, 32'h0);
    chk("b2_id", {16'd0, mem[4], mem[5]}, 32'h0001);
    chk("b2_csum", {16'd0, mem[10], mem[11]}, 32'(CK2));
    chk("b2_ident", 32'(o_ident), 32'h0002);

    // Build 3: set src during the build; the change is deferred until after DONE
    tick();
    build(16'h0008, 0, 8, 32'h0A000001);
    chk("b3_src_kept", {mem[12], mem[13], mem[14], mem[15]}, 32'hC0A80104);
    chk("b3_local_at_done", o_local_ip, 32'hC0A80104);
    tick(); tick();
    chk("b3_local_in_set", o_local_ip, 32'hC0A80104);
    tick();
    chk("b3_local_after_set", o_local_ip, 32'h0A000001);
    chk("b3_ready_held", 32'(o_ready), 32'd1);
    chk("b3_ident", 32'(o_ident), 32'h0003);

    // Build 4: the header uses the new src
    build(16'h0008, 0, 0, 32'h0A000001);
    chk("b4_src_new", {mem[12], mem[13], mem[14], mem[15]}, 32'h0A000001);
    chk("b4_csum", {16'd0, mem[10], mem[11]},
        32'(csum_model(TOT, 16'h0003, 32'h0A000001, 32'hC0A80105)));

    // Build 5: a second trigger mid-sweep is ignored
    tick();
    build(16'h0008, 5, 0, 32'h0A000001);
    chk("b5_nwrites", 32'(nwr), 32'(HL + 2));
    chk("b5_latency", 32'(lat), 32'(HL + 3));
    chk("b5_ident", 32'(o_ident), 32'h0005);

    // Ident wrap from FFFF
    tick();
    force dut.ident = 16'hFFFF;
    tick();
    release dut.ident;
    tick();
    chk("wrap_pre", 32'(o_ident), 32'h0000FFFF);
    build(16'h0008, 0, 0, 32'h0A000001);
    chk("wrap_id_bytes", {16'd0, mem[4], mem[5]}, 32'h0000FFFF);
    chk("wrap_csum", {16'd0, mem[10], mem[11]},
        32'(csum_model(TOT, 16'hFFFF, 32'h0A000001, 32'hC0A80105)));
    chk("wrap_ident", 32'(o_ident), 32'h0000);

    // Reset at the seventh write aborts the build
    tick();
    i_data_length = 16'h0008;
    i_trig = 1'b1;
    tick();
    i_trig = 1'b0;
    nwr = 0;
    lat = 0;
    while (nwr < 7 && lat < 40) begin
      if (o_wr_en) nwr++;
      if (nwr < 7) begin
        tick();
        lat++;
      end
    end
    chk("rst7_reached", 32'(nwr), 32'd7);
    i_rst_n = 1'b0;
    #1;
    chk("rst7_wr_en", 32'(o_wr_en), 32'd0);
    chk("rst7_idx", 32'(o_hdr_idx), 32'd0);
    chk("rst7_byte", 32'(o_hdr_byte), 32'd0);
    chk("rst7_busy", 32'(o_busy), 32'd0);
    chk("rst7_ready", 32'(o_ready), 32'd0);
    chk("rst7_ident", 32'(o_ident), 32'd0);
    chk("rst7_local_ip", o_local_ip, 32'hC0A80104);
    tick(); tick();
    chk("rst7_hold_wr_en", 32'(o_wr_en), 32'd0);
    i_rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_idle_wr", 32'(o_wr_en), 32'd0);

    // A build after reset goes back to the reset IPs and ID
    build(16'h0008, 0, 0, 32'h0A000001);
    chk("pr_csum", {16'd0, mem[10], mem[11]}, 32'(CK1));
    chk("pr_ident", 32'(o_ident), 32'h0001);
    chk("pr_latency", 32'(lat), 32'(HL + 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
